// File: rtl/rob_retire.sv
// rob_retire: in-order reorder buffer with a three-wide commit stage that
// drives an architectural register file sharing one write enable across
// its three retire ports. Slots that have nothing to write repeat the
// youngest real write, so the ARF can apply all three slots unconditionally.
// Optional build macro: ROB_X0_FILTER_EN (rd_addr 0 retires as a non-writer).
module rob_retire #(
  parameter int AR_SIZE  = 7,
  parameter int ROB_SIZE = 16,
  parameter int ROB_IDX  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic               alloc_has_rd,
  input  logic [AR_SIZE-1:0] alloc_rd_addr,
  output logic [ROB_IDX-1:0] alloc_idx,
  input  logic               cmpl0_valid,
  input  logic [ROB_IDX-1:0] cmpl0_idx,
  input  logic [31:0]        cmpl0_data,
  input  logic               cmpl1_valid,
  input  logic [ROB_IDX-1:0] cmpl1_idx,
  input  logic [31:0]        cmpl1_data,
  output logic               retire_en,
  output logic [AR_SIZE-1:0] retire_addr1,
  output logic [AR_SIZE-1:0] retire_addr2,
  output logic [AR_SIZE-1:0] retire_addr3,
  output logic [31:0]        retire_data1,
  output logic [31:0]        retire_data2,
  output logic [31:0]        retire_data3,
  output logic [2:0]         retire_valid,
  output logic [ROB_IDX:0]   rob_count,
  output logic               rob_empty
);

  localparam logic [ROB_IDX:0] LP_FULL = (ROB_IDX+1)'(ROB_SIZE);

  // entry control state (reset) and payload (no reset needed)
  logic [ROB_SIZE-1:0] r_valid;
  logic [ROB_SIZE-1:0] r_done;
  logic [ROB_SIZE-1:0] r_has_rd;
  logic [AR_SIZE-1:0]  r_rd_addr [ROB_SIZE];
  logic [31:0]         r_data    [ROB_SIZE];
  logic [ROB_IDX-1:0]  r_head;
  logic [ROB_IDX-1:0]  r_tail;
  logic [ROB_IDX:0]    r_count;

  // registered retire bundle
  logic                r_ret_en;
  logic [2:0]          r_ret_vld;
  logic [AR_SIZE-1:0]  r_ret_addr [3];
  logic [31:0]         r_ret_data [3];

  logic                w_alloc;
  logic [ROB_IDX-1:0]  w_idx [3];
  logic [2:0]          w_ret;
  logic [2:0]          w_wr;
  logic [ROB_IDX:0]    w_nret;
  logic [AR_SIZE-1:0]  w_y_addr;
  logic [31:0]         w_y_data;
  logic [AR_SIZE-1:0]  w_slot_addr [3];
  logic [31:0]         w_slot_data [3];

  // full/empty come from registered count only; a same-cycle retire does not free space
  assign alloc_ready = (r_count != LP_FULL);
  assign w_alloc     = alloc_valid && alloc_ready;
  assign alloc_idx   = r_tail;
  assign rob_count   = r_count;
  assign rob_empty   = (r_count == '0);

  assign retire_en    = r_ret_en;
  assign retire_valid = r_ret_vld;
  assign retire_addr1 = r_ret_addr[0];
  assign retire_addr2 = r_ret_addr[1];
  assign retire_addr3 = r_ret_addr[2];
  assign retire_data1 = r_ret_data[0];
  assign retire_data2 = r_ret_data[1];
  assign retire_data3 = r_ret_data[2];

  // pick up to three consecutive done head entries and build the slot bundle
  always_comb begin
    logic v_run;
    v_run    = 1'b1;
    w_ret    = '0;
    w_wr     = '0;
    w_nret   = '0;
    w_y_addr = '0;
    w_y_data = '0;
    for (int i = 0; i < 3; i++) begin
      w_idx[i] = r_head + ROB_IDX'(i);
      v_run    = v_run && r_valid[w_idx[i]] && r_done[w_idx[i]];
      w_ret[i] = v_run;
`ifdef ROB_X0_FILTER_EN
      w_wr[i]  = v_run && r_has_rd[w_idx[i]] && (r_rd_addr[w_idx[i]] != '0);
`else
      w_wr[i]  = v_run && r_has_rd[w_idx[i]];
`endif
      // later (younger) writers override, leaving the youngest writer
      if (w_wr[i]) begin
        w_y_addr = r_rd_addr[w_idx[i]];
        w_y_data = r_data[w_idx[i]];
      end
      w_nret = w_nret + (ROB_IDX+1)'(v_run);
    end
    for (int i = 0; i < 3; i++) begin
      w_slot_addr[i] = w_wr[i] ? r_rd_addr[w_idx[i]] : w_y_addr;
      w_slot_data[i] = w_wr[i] ? r_data[w_idx[i]]    : w_y_data;
    end
  end

  // pointers, entry valid/done and retire outputs; flush beats everything else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      r_done    <= '0;
      r_ret_en  <= 1'b0;
      r_ret_vld <= '0;
      for (int i = 0; i < 3; i++) begin
        r_ret_addr[i] <= '0;
        r_ret_data[i] <= '0;
      end
    end else if (flush) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      r_done    <= '0;
      r_ret_en  <= 1'b0;
      r_ret_vld <= '0;
      for (int i = 0; i < 3; i++) begin
        r_ret_addr[i] <= '0;
        r_ret_data[i] <= '0;
      end
    end else begin
      if (cmpl1_valid && r_valid[cmpl1_idx]) r_done[cmpl1_idx] <= 1'b1;
      if (cmpl0_valid && r_valid[cmpl0_idx]) r_done[cmpl0_idx] <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (w_ret[i]) begin
          r_valid[w_idx[i]] <= 1'b0;
          r_done[w_idx[i]]  <= 1'b0;
        end
      end
      // tail entry is never among the retirees unless full, and full blocks alloc
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
      r_head    <= r_head + w_nret[ROB_IDX-1:0];
      r_count   <= r_count + (ROB_IDX+1)'(w_alloc) - w_nret;
      r_ret_en  <= |w_wr;
      r_ret_vld <= w_ret;
      for (int i = 0; i < 3; i++) begin
        r_ret_addr[i] <= w_slot_addr[i];
        r_ret_data[i] <= w_slot_data[i];
      end
    end
  end

  // entry payload: destination at dispatch, result at completion (port0 wins)
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_has_rd[r_tail]  <= alloc_has_rd;
      r_rd_addr[r_tail] <= alloc_rd_addr;
    end
    if (cmpl1_valid && r_valid[cmpl1_idx]) r_data[cmpl1_idx] <= cmpl1_data;
    if (cmpl0_valid && r_valid[cmpl0_idx]) r_data[cmpl0_idx] <= cmpl0_data;
  end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order reorder buffer and commit stage feeding the architectural register file's three-port retire interface.
- Accepts one dispatched instruction per cycle and takes results from two completion ports.
- Retires up to three consecutive completed head entries per cycle, in program order.
- Drives the retire address/data/enable bundle with the ARF's single shared write enable; unused slots are made harmless.

Parameters:
- AR_SIZE, 7, architectural register address width (128 registers).
- ROB_SIZE, 16, ROB entries; must be a power of two and at least 4.
- ROB_IDX, 4, log2(ROB_SIZE); entry index width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all entries.
- alloc_valid  in  1  dispatch request.
- alloc_ready  out  1  ROB not full.
- alloc_has_rd  in  1  instruction writes a destination.
- alloc_rd_addr  in  AR_SIZE  destination register.
- alloc_idx  out  ROB_IDX  current tail index, returned to dispatch.
- cmpl0_valid, cmpl1_valid  in  1  completion strobes.
- cmpl0_idx, cmpl1_idx  in  ROB_IDX  completing entry.
- cmpl0_data, cmpl1_data  in  32  result value.
- retire_en  out  1  shared ARF write enable.
- retire_addr1/2/3  out  AR_SIZE  ARF write addresses; slot1 oldest.
- retire_data1/2/3  out  32  ARF write data.
- retire_valid  out  3  per-slot retired flag; bit0 = slot1.
- rob_count  out  ROB_IDX+1  occupied entries.
- rob_empty  out  1  rob_count == 0.

Behaviour:
- Reset (async, rstn low):
  - head, tail and count are 0; all entry valid/done bits cleared.
  - retire_en = 0, retire_valid = 0, all retire addr/data = 0.
  - alloc_ready = 1, rob_empty = 1.
- Entry fields: valid, done, has_rd, rd_addr, data.
- Allocation: when alloc_valid && alloc_ready at the edge:
  - the entry at tail is written with valid=1, done=0;
  - tail advances by 1, wrapping modulo ROB_SIZE.
  - alloc_ready = (rob_count != ROB_SIZE). It comes from registered state only, so same-cycle retire does not free space for allocation.
- Completion:
  - cmpl valid on a valid entry sets done=1 and captures data.
  - Completion to an invalid entry is ignored.
  - Both ports on the same idx: port0 wins.
  - Done set at edge E is first visible to retire at edge E+1.
- Retire, evaluated each edge from registered state:
  - k = number of consecutive valid&&done entries starting at head, capped at 3.
  - Retired entries are cleared; head advances by k (wrap); count becomes count + alloc − k.
- Retire outputs are registered and pulse for exactly one cycle after the retiring edge:
  - slot i (i<k) carries entry head+i's rd_addr/data;
  - retire_valid[i] = 1 for i<k.
- Shared-enable rule:
  - retire_en = 1 iff at least one retired entry has has_rd=1.
  - Retired slots with has_rd=0, and slots i>=k, are overwritten with addr/data of the youngest has_rd slot among the retirees.
  - Because the ARF applies slot3 last, the youngest write to a duplicated register always wins.
  - With no writer, retire_en = 0 and addr/data are 0.
- Latency: alloc edge E0 → earliest completion edge E1 → retire outputs valid after E2.
- flush:
  - has priority over alloc, completion and retire in the same cycle;
  - clears all entries and pointers;
  - next-cycle retire_en/retire_valid = 0.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro ROB_X0_FILTER_EN.
- Defined: an entry with rd_addr == 0 is treated as has_rd = 0 at retire. It never drives retire_en and gets the duplicate-slot substitution.
- Undefined: rd_addr 0 is retired like any other register.

Test Plan:
- Reset then alloc rd=5, complete data 0xAAAA_0001:
  - retire_en=1, retire_valid=3'b001, addr1=addr2=addr3=5, all data 0xAAAA_0001, for exactly one cycle;
  - rob_empty=1 afterwards.
- Alloc 4 entries rd=1,2,3,4, complete all in reverse order:
  - first retire cycle: slots rd 1,2,3, valid=3'b111;
  - next retire cycle: rd 4 in all slots, valid=3'b001.
- Alloc rd=7 (data 0x11) then rd=7 (data 0x22), both done:
  - one cycle with valid=3'b011, addr3=7, data3=0x22; ARF ends with 0x22.
- Alloc entries with has_rd 1 (rd=9), 0, 0, all done:
  - valid=3'b111, retire_en=1, all three slots rd 9.
- Fill 16 entries:
  - alloc_ready=0, rob_count=16; further alloc_valid ignored.
  - Complete head: alloc_ready returns only after the retire edge.
- Fill 5 entries, complete 2, assert flush together with cmpl:
  - no retire pulse, rob_count=0, alloc_idx=0 next cycle.
  - With ROB_X0_FILTER_EN: a rd=0 lone retiree gives retire_en=0, valid=3'b001.
